c17_eval_sched: RTL
===================

Name: c17_eval_sched

Overview:
- Round-robin scheduler that time-shares one c17 evaluation unit (5 primary inputs pi0..pi4, 2 primary outputs po0/po1) among NUM_REQ requesters.
- Accepts one operand vector at a time, issues it to the shared unit, waits a fixed EVAL_LAT cycles, then returns the 2-bit result to the originating requester with backpressure.
- Sits between requester-side ready/valid channels and the combinational or pipelined c17 instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- EVAL_LAT, 2, cycles from ev_start to valid ev_po (1..15).
- IDX_W, 2, width of a requester index; must be at least clog2(NUM_REQ).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_pi  input  5*NUM_REQ  operand for requester i in bits [5i+4:5i], bit order {pi4..pi0}.
- req_ready  output  NUM_REQ  one-hot accept, combinational from state and req_valid.
- rsp_valid  output  NUM_REQ  one-hot result valid.
- rsp_po  output  2  result {po1,po0}, shared by all requesters.
- rsp_ready  input  NUM_REQ  per-requester result ready.
- ev_pi  output  5  operand to evaluation unit.
- ev_start  output  1  one-cycle issue pulse.
- ev_po  input  2  evaluation unit result {po1,po0}.
- busy  output  1  high in any state other than IDLE.
- done_cnt  output  16  completed transactions; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (async assert, sync-released by the system): state=IDLE, rr_ptr=0, and every output is 0 (req_ready, rsp_valid, rsp_po, ev_pi, ev_start, busy, done_cnt).
- The FSM has three states: IDLE, EVAL and RESP.
- IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is the grant g. req_ready[g]=1; all other req_ready bits are 0.
  - On the clock edge where req_ready[g]&req_valid[g]: latch req_pi slice g into ev_pi, store g, load cnt=EVAL_LAT-1, go to EVAL.
  - With no req_valid bit set, stay in IDLE with req_ready=0.
- EVAL:
  - ev_start=1 in the first EVAL cycle only.
  - ev_pi is held stable throughout EVAL.
  - Each cycle: if cnt==0, capture ev_po into rsp_po and go to RESP; otherwise cnt decrements.
  - Net effect: the capture edge is the end of cycle T+EVAL_LAT, where T is the acceptance cycle.
  - req_ready is 0 in every state except IDLE.
- RESP:
  - rsp_valid[g]=1 and rsp_po is held.
  - On rsp_ready[g]: rsp_valid drops the next cycle, done_cnt increments, rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
  - Stalls indefinitely without rsp_ready[g].
- Throughput: at most one transaction per EVAL_LAT+2 cycles. Zero-stall latency from acceptance to rsp_valid is EVAL_LAT+1 cycles.
- Fairness:
  - A requester holding req_valid is granted within NUM_REQ transactions.
  - The pointer advances only on completion, never on idle cycles.
- Requester rules:
  - Requesters may drop req_valid before acceptance.
  - req_pi is sampled only on the handshake edge.
- Mid-operation reset: any state returns to IDLE asynchronously, any outstanding result is lost, done_cnt clears.
- ev_po is ignored outside the capture edge.
- busy is a registered decode of state (0 in IDLE).

Test Plan:
- Reset: hold rst_n=0 mid-EVAL -> all outputs 0 immediately, state IDLE; first request after release is granted to requester 0 when all are valid.
- Single request, bench models c17, EVAL_LAT=2:
  - req 1 sends pi=5'b00101 -> ev_start one cycle after acceptance.
  - rsp_valid[1] asserts 3 cycles after acceptance with rsp_po=2'b01.
  - done_cnt=1.
- Round-robin: all four req_valid held, rsp_ready=all ones -> grant order 0,1,2,3,0, each 4 cycles apart.
- Backpressure:
  - req 2 sends pi=5'b10010, rsp_ready[2] held low for 10 cycles -> rsp_valid[2] and rsp_po=2'b11 stable, no new grants, busy=1.
  - Completes on rsp_ready.
- Wrong-ready and operand change: req 0 sends 5'b01110 while rsp_ready[3] only is asserted -> no completion; req_pi changing after acceptance does not change ev_pi; final rsp_po=2'b00.
- Counter wrap: preload by running 65536 transactions (or force) -> done_cnt reads 0 after the 65536th.

Source files
------------

// File: rtl/c17_eval_sched.sv
// c17_eval_sched: round-robin scheduler sharing one c17 evaluation unit among NUM_REQ requesters
module c17_eval_sched #(
   parameter int NUM_REQ  = 4,
   parameter int EVAL_LAT = 2,
   parameter int IDX_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [5*NUM_REQ-1:0]   req_pi,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [1:0]             rsp_po,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [4:0]             ev_pi,
   output logic                   ev_start,
   input  logic [1:0]             ev_po,
   output logic                   busy,
   output logic [15:0]            done_cnt
);
   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
   state_t             state_q;
   logic [IDX_W-1:0]   rr_ptr_q, gnt_q, gnt_d, cand;
   logic               gnt_vld_d;
   logic [3:0]         cnt_q;
   logic [4:0]         ev_pi_q;
   logic               ev_start_q, busy_q;
   logic [1:0]         rsp_po_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [15:0]        done_cnt_q;
   // grant search from rr_ptr; scanning offsets high to low lets the nearest valid requester win
   always_comb begin
      gnt_d     = rr_ptr_q;
      gnt_vld_d = 1'b0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            gnt_d     = cand;
            gnt_vld_d = 1'b1;
         end
      end
   end
   // accept is offered only in IDLE and is forced low while reset is asserted
   always_comb begin
      req_ready = (rst_n && state_q == IDLE && gnt_vld_d) ? NUM_REQ'(1) << gnt_d : '0;
   end
   // issue / count-down / respond sequencing with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         cnt_q       <= '0;
         ev_pi_q     <= '0;
         ev_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         rsp_po_q    <= '0;
         rsp_valid_q <= '0;
         done_cnt_q  <= '0;
      end else begin
         ev_start_q <= 1'b0;
         if (state_q == IDLE) begin
            if (gnt_vld_d) begin
               ev_pi_q    <= req_pi[5*gnt_d +: 5];
               gnt_q      <= gnt_d;
               cnt_q      <= 4'(EVAL_LAT - 1);
               ev_start_q <= 1'b1;
               busy_q     <= 1'b1;
               state_q    <= EVAL;
            end
         end else if (state_q == EVAL) begin
            if (cnt_q == 4'd0) begin
               rsp_po_q    <= ev_po;
               rsp_valid_q <= NUM_REQ'(1) << gnt_q;
               state_q     <= RESP;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
         end else if (state_q == RESP) begin
            if (rsp_ready[gnt_q]) begin
               rsp_valid_q <= '0;
               done_cnt_q  <= done_cnt_q + 16'd1;
               rr_ptr_q    <= (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
         end
      end
   end
   assign ev_pi     = ev_pi_q;
   assign ev_start  = ev_start_q;
   assign busy      = busy_q;
   assign rsp_po    = rsp_po_q;
   assign rsp_valid = rsp_valid_q;
   assign done_cnt  = done_cnt_q;
endmodule
